ahb_lite_sram_slave: RTL

//  Parametrised AHB-Lite subordinate backed by a byte-enabled word memory; next generation of our AHB slave block.

---
 rtl/ahb_lite_sram_slave_pkg.sv | 62 ++++++
 rtl/ahb_lite_sram_slave_if.sv | 27 ++
 rtl/ahb_lite_sram_slave_byte_mem.sv | 26 ++
 rtl/ahb_lite_sram_slave.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared types and helpers for the AHB-Lite SRAM subordinate: transfer
// encodings, FSM states and byte-lane strobe generation.
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Low address bits that must be zero for a transfer of the given size.
  function automatic logic [2:0] align_mask(input logic [2:0] size);
    case (size)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Little-endian lane enables; caller passes an already aligned lsb.
  function automatic logic [7:0] byte_strobe(input logic [2:0] size,
                                             input logic [2:0] addr_lsb,
                                             input int nbytes);
    logic [7:0] mask;
    logic [2:0] lsb;
    case (size)
      3'd0:    mask = 8'h01;
      3'd1:    mask = 8'h03;
      3'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    lsb = addr_lsb;
    if (nbytes == 4) begin
      mask = mask & 8'h0F;
      lsb  = {1'b0, addr_lsb[1:0]};
    end
    return mask << lsb;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between the decoder/master side and the SRAM subordinate.
interface ahb_lite_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic [1:0]        HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HBURST, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HBURST, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_lite_sram_slave_byte_mem.sv
// Word-organised storage with per-byte write enables and a combinational read.
// Contents are intentionally not reset.
module ahb_slv_byte_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM subordinate with programmable wait states and byte-lane writes.
// Define AHB_SLV_ERR_EN to answer illegal accesses with a two-cycle ERROR.
//
// state   | meaning
// IDLE    | no data phase in progress, ready
// WAIT    | inserting wait states, HREADYOUT low
// DATA    | final data-phase cycle: read data driven / write committed
// ERR1    | first ERROR cycle, HREADYOUT low
// ERR2    | second ERROR cycle, HREADYOUT high
module ahb_lite_sram_slave
  import ahb_slv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahb_lite_sram_slave_if.slave bus
);
  localparam int NB      = DATA_W / 8;
  localparam int LANE_W  = $clog2(NB);
  localparam int WORD_AW = $clog2(DEPTH);
  localparam int SPAN_W  = WORD_AW + LANE_W;
  localparam int SPAN    = DEPTH * NB;

  slv_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic              wr_q;
  logic              ready;
  logic              accept;
  logic              legal;

  assign ready  = !(state_q == ST_WAIT || state_q == ST_ERR1);
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & ready;

`ifdef AHB_SLV_ERR_EN
  logic in_range, size_ok, aligned;
  assign in_range = {1'b0, bus.HADDR} < (ADDR_W+1)'(SPAN);
  assign size_ok  = bus.HSIZE <= 3'(LANE_W);
  assign aligned  = (bus.HADDR[LANE_W-1:0] & LANE_W'(align_mask(bus.HSIZE))) == '0;
  assign legal    = in_range & size_ok & aligned;
`else
  assign legal = 1'b1;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= bus.HADDR;
        size_q <= bus.HSIZE;
        wr_q   <= bus.HWRITE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!accept) begin
          state_d = ST_IDLE;
        end else if (!legal) begin
          state_d = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Unselected address bits wrap and low bits are masked off, so the memory
  // side never sees an out-of-range or misaligned access in either build.
  logic [2:0]         eff_size;
  logic [LANE_W-1:0]  lsb_al;
  logic [WORD_AW-1:0] word_addr;
  logic [NB-1:0]      strobe;
  logic [DATA_W-1:0]  rdata;
  logic               we;

  assign eff_size  = (size_q > 3'(LANE_W)) ? 3'(LANE_W) : size_q;
  assign lsb_al    = addr_q[LANE_W-1:0] & ~LANE_W'(align_mask(eff_size));
  assign word_addr = addr_q[SPAN_W-1:LANE_W];
  assign strobe    = NB'(byte_strobe(eff_size, 3'(lsb_al), NB));
  assign we        = (state_q == ST_DATA) & wr_q;

  ahb_slv_byte_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (HCLK),
    .we    (we),
    .waddr (word_addr),
    .be    (strobe),
    .wdata (bus.HWDATA),
    .raddr (word_addr),
    .rdata (rdata)
  );

  assign bus.HREADYOUT = ready;
  assign bus.HRDATA    = (state_q == ST_DATA) ? rdata : '0;
`ifdef AHB_SLV_ERR_EN
  assign bus.HRESP = (state_q == ST_ERR1 || state_q == ST_ERR2) ? ERROR : OKAY;
`else
  assign bus.HRESP = OKAY;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HTRANS[0], addr_q};
endmodule
